// File: rtl/dotp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dotp_arbiter
// Purpose  : Round-robin owner selection for one shared 8-lane dot-product
//            engine; latches operands, runs start/done, returns the result.
// Revision : 1.0  initial release
// ============================================================================
module dotp_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NREQ-1:0]                  req,
    input  logic [NREQ-1:0][7:0][31:0]       req_a,
    input  logic [NREQ-1:0][7:0][31:0]       req_b,
    output logic [NREQ-1:0]                  gnt,
    output logic [NREQ-1:0]                  rsp_valid,
    input  logic [NREQ-1:0]                  rsp_ready,
    output logic [63:0]                      rsp_data,
    output logic                             rsp_err,
    output logic                             busy,
    output logic [7:0][31:0]                 acc_a,
    output logic [7:0][31:0]                 acc_b,
    output logic                             acc_start,
    input  logic                             acc_done,
    input  logic [63:0]                      acc_result
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_owner;
    logic [TW-1:0]   r_timer;

    logic            w_found;
    logic [IW-1:0]   w_sel;
    logic [IW:0]     w_sum;
    logic [NREQ-1:0] w_gnt_oh;
    logic [NREQ-1:0] w_owner_oh;

    // Scan from the round-robin pointer, wrapping at NREQ (not a power of two in general).
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(NREQ))
                w_sum = w_sum - (IW+1)'(NREQ);
            if (!w_found && req[w_sum[IW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[IW-1:0];
            end
        end
    end

    assign w_gnt_oh   = NREQ'(1) << w_sel;
    assign w_owner_oh = NREQ'(1) << r_owner;
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_timer   <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            acc_a     <= '0;
            acc_b     <= '0;
            acc_start <= 1'b0;
        end else begin
            gnt <= '0;
            case (r_state)
                S_IDLE: begin
                    // A done still high from the previous job must drop before a new grant.
                    if (w_found && !acc_done) begin
                        gnt     <= w_gnt_oh;
                        acc_a   <= req_a[w_sel];
                        acc_b   <= req_b[w_sel];
                        r_owner <= w_sel;
                        r_ptr   <= (w_sel == IW'(NREQ-1)) ? '0 : w_sel + IW'(1);
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    acc_start <= 1'b1;
                    r_timer   <= '0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    r_timer <= r_timer + TW'(1);
                    if (acc_done) begin
                        rsp_data  <= acc_result;
                        rsp_err   <= 1'b0;
                        rsp_valid <= w_owner_oh;
                        acc_start <= 1'b0;
                        r_state   <= S_RESP;
                    end else if (r_timer == TW'(TIMEOUT_CYC-1)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= w_owner_oh;
                        acc_start <= 1'b0;
                        r_state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    acc_start <= 1'b0;
                    if (rsp_ready[r_owner]) begin
                        rsp_valid <= '0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dotp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dotp_arbiter
// Purpose  : Self-checking bench for dotp_arbiter with a behavioural engine.
// Revision : 1.0  initial release
// ============================================================================
module tb_dotp_arbiter;

    localparam int NREQ    = 4;
    localparam int TMO     = 64;
    localparam int ENG_LAT = 9;
    localparam int BUDGET  = 200;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [NREQ-1:0]             req = '0;
    logic [NREQ-1:0][7:0][31:0]  ra = '0;
    logic [NREQ-1:0][7:0][31:0]  rb = '0;
    logic [NREQ-1:0]             gnt;
    logic [NREQ-1:0]             rsp_valid;
    logic [NREQ-1:0]             rsp_ready = '0;
    logic [63:0]                 rsp_data;
    logic                        rsp_err;
    logic                        busy;
    logic [7:0][31:0]            acc_a;
    logic [7:0][31:0]            acc_b;
    logic                        acc_start;
    logic                        acc_done;
    logic [63:0]                 acc_result;

    logic                        done_en = 1'b1;
    logic                        force_done = 1'b0;
    logic                        m_done;
    int                          m_cnt;
    logic [63:0]                 m_res;

    int n_tests = 0;
    int n_fail  = 0;

    int           j_idx, j_lat, j_xg;
    logic [63:0]  j_data;
    logic         j_err;
    logic [NREQ-1:0] j_vld, j_va;
    bit           j_stable;

    always #5 clk = ~clk;

    dotp_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(ra), .req_b(rb),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .acc_a(acc_a), .acc_b(acc_b), .acc_start(acc_start),
        .acc_done(acc_done), .acc_result(acc_result)
    );

    function automatic longint dot(input logic [7:0][31:0] a, input logic [7:0][31:0] b);
        longint s = 0;
        for (int k = 0; k < 8; k++)
            s += longint'(signed'(a[k])) * longint'(signed'(b[k]));
        return s;
    endfunction

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        if ($countones(v) != 1) return -2;
        for (int k = 0; k < NREQ; k++) if (v[k]) return k;
        return -2;
    endfunction

    // Engine stand-in: ENG_LAT start-high cycles, then done held until start drops.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_done <= 1'b0; m_cnt <= 0; m_res <= '0;
        end else if (!acc_start) begin
            m_done <= 1'b0; m_cnt <= 0;
        end else if (!m_done && done_en) begin
            if (m_cnt == ENG_LAT-1) begin
                m_done <= 1'b1;
                m_res  <= dot(acc_a, acc_b);
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end
    assign acc_done   = m_done | force_done;
    assign acc_result = m_res;

    task automatic do_reset();
        rst = 1'b1; req = '0; rsp_ready = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic rand_vec(input int i);
        for (int k = 0; k < 8; k++) begin
            ra[i][k] = $urandom;
            rb[i][k] = $urandom;
        end
    endtask

    // One job: request, wait grant, scramble owner's operands, wait response,
    // optionally backpressure for `hold` cycles, then handshake.
    task automatic job(input logic [NREQ-1:0] mask, input bit keep, input logic [NREQ-1:0] bg,
                       input int hold, output int gidx, output int lat, output logic [63:0] data,
                       output logic err, output logic [NREQ-1:0] vld, output bit stable,
                       output int xg, output logic [NREQ-1:0] va);
        int cyc;
        gidx = -1; lat = -1; data = '0; err = 1'b0; vld = '0; stable = 1'b1; xg = 0; va = '1;
        req = mask;
        cyc = 0;
        while (cyc < BUDGET && gidx == -1) begin
            @(negedge clk); cyc++;
            if (gnt != '0) gidx = oh_idx(gnt);
        end
        if (gidx < 0) begin req = '0; return; end
        if (!keep) req[gidx] = 1'b0;
        rand_vec(gidx);
        cyc = 0;
        while (cyc < BUDGET && vld == '0) begin
            @(negedge clk); cyc++;
            if (gnt != '0) xg++;
            if (rsp_valid != '0) begin
                vld = rsp_valid; data = rsp_data; err = rsp_err; lat = cyc;
            end
        end
        if (vld == '0) begin req = '0; return; end
        req = req | bg;
        rsp_ready = ~(NREQ'(1) << gidx);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (rsp_valid !== vld || rsp_data !== data || rsp_err !== err || busy !== 1'b1)
                stable = 1'b0;
            if (gnt != '0) xg++;
        end
        req = req & ~bg;
        rsp_ready = '0;
        rsp_ready[gidx] = 1'b1;
        @(negedge clk);
        va = rsp_valid;
        rsp_ready = '0;
        if (!keep) req = '0;
    endtask

    task automatic test_reset();
        n_tests++; if (gnt !== '0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", gnt); end
        n_tests++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        n_tests++; if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (acc_start !== 1'b0) begin n_fail++; $display("FAIL reset_acc_start: got %b want 0", acc_start); end
        n_tests++; if (acc_a !== '0 || acc_b !== '0) begin n_fail++; $display("FAIL reset_operands: got a=%h b=%h want 0", acc_a, acc_b); end
    endtask

    task automatic test_single();
        for (int k = 0; k < 8; k++) begin ra[0][k] = 32'(k + 1); rb[0][k] = 32'd2; end
        job(4'b0001, 1'b0, '0, 0, j_idx, j_lat, j_data, j_err, j_vld, j_stable, j_xg, j_va);
        n_tests++; if (j_idx !== 0) begin n_fail++; $display("FAIL single_gnt: got %0d want 0", j_idx); end
        n_tests++; if (j_lat !== 11) begin n_fail++; $display("FAIL single_latency: got %0d want 11", j_lat); end
        n_tests++; if (j_data !== 64'd72) begin n_fail++; $display("FAIL single_data: got %0d want 72", $signed(j_data)); end
        n_tests++; if (j_err !== 1'b0 || j_vld !== 4'b0001) begin n_fail++; $display("FAIL single_rsp: got err=%b vld=%b want 0/0001", j_err, j_vld); end
        n_tests++; if (j_va !== '0) begin n_fail++; $display("FAIL single_handshake: got vld=%b want 0", j_va); end
    endtask

    task automatic test_signed();
        longint x;
        for (int k = 0; k < 8; k++) begin ra[2][k] = -32'sd3; rb[2][k] = 32'sd5; end
        job(4'b0100, 1'b0, '0, 0, j_idx, j_lat, j_data, j_err, j_vld, j_stable, j_xg, j_va);
        n_tests++; if (j_data !== 64'(-120) || j_idx !== 2) begin n_fail++; $display("FAIL signed_neg: got %0d idx %0d want -120 idx 2", $signed(j_data), j_idx); end
        for (int k = 0; k < 8; k++) begin ra[3][k] = 32'h7FFFFFFF; rb[3][k] = 32'h7FFFFFFF; end
        x = 64'h7FFFFFFF;
        x = 8 * (x * x);
        job(4'b1000, 1'b0, '0, 0, j_idx, j_lat, j_data, j_err, j_vld, j_stable, j_xg, j_va);
        n_tests++; if (j_data !== x) begin n_fail++; $display("FAIL signed_max: got %h want %h", j_data, x); end
    endtask

    task automatic test_random();
        int i;
        longint e;
        for (int n = 0; n < 8; n++) begin
            i = $urandom_range(0, NREQ-1);
            rand_vec(i);
            e = dot(ra[i], rb[i]);
            job(NREQ'(1) << i, 1'b0, '0, 0, j_idx, j_lat, j_data, j_err, j_vld, j_stable, j_xg, j_va);
            n_tests++;
            if (j_idx !== i || j_data !== e || j_lat !== 11 || j_err !== 1'b0 || j_vld !== (NREQ'(1) << i)) begin
                n_fail++;
                $display("FAIL random_job%0d: got idx=%0d data=%h lat=%0d err=%b want idx=%0d data=%h lat=11 err=0",
                         n, j_idx, j_data, j_lat, j_err, i, e);
            end
        end
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int n = 0; n < 5; n++) begin
            job(4'b1111, (n < 4), '0, 0, j_idx, j_lat, j_data, j_err, j_vld, j_stable, j_xg, j_va);
            n_tests++; if (j_idx !== order[n]) begin n_fail++; $display("FAIL rr_order%0d: got %0d want %0d", n, j_idx, order[n]); end
        end
        job(4'b0100, 1'b0, '0, 0, j_idx, j_lat, j_data, j_err, j_vld, j_stable, j_xg, j_va);
        n_tests++; if (j_idx !== 2) begin n_fail++; $display("FAIL rr_single2: got %0d want 2", j_idx); end
        job(4'b0101, 1'b0, '0, 0, j_idx, j_lat, j_data, j_err, j_vld, j_stable, j_xg, j_va);
        n_tests++; if (j_idx !== 0) begin n_fail++; $display("FAIL rr_wrap: got %0d want 0", j_idx); end
    endtask

    task automatic test_backpressure();
        longint e;
        rand_vec(1);
        e = dot(ra[1], rb[1]);
        job(4'b0010, 1'b0, 4'b1101, 20, j_idx, j_lat, j_data, j_err, j_vld, j_stable, j_xg, j_va);
        n_tests++; if (j_idx !== 1 || j_data !== e) begin n_fail++; $display("FAIL bp_result: got idx=%0d data=%h want 1/%h", j_idx, j_data, e); end
        n_tests++; if (j_stable !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got %b want 1", j_stable); end
        n_tests++; if (j_xg !== 0) begin n_fail++; $display("FAIL bp_no_gnt: got %0d grants want 0", j_xg); end
        n_tests++; if (j_va !== '0) begin n_fail++; $display("FAIL bp_release: got vld=%b want 0", j_va); end
    endtask

    task automatic test_timeout();
        done_en = 1'b0;
        rand_vec(2);
        job(4'b0100, 1'b0, '0, 0, j_idx, j_lat, j_data, j_err, j_vld, j_stable, j_xg, j_va);
        done_en = 1'b1;
        n_tests++; if (j_lat !== TMO + 1) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", j_lat, TMO + 1); end
        n_tests++; if (j_err !== 1'b1 || j_data !== '0 || j_vld !== 4'b0100) begin n_fail++; $display("FAIL timeout_rsp: got err=%b data=%h vld=%b want 1/0/0100", j_err, j_data, j_vld); end
    endtask

    task automatic test_done_block();
        int cnt = 0;
        force_done = 1'b1;
        req = 4'b0001;
        repeat (6) begin @(negedge clk); if (gnt != '0 || busy) cnt++; end
        force_done = 1'b0;
        n_tests++; if (cnt !== 0) begin n_fail++; $display("FAIL done_blocks_gnt: got %0d active cycles want 0", cnt); end
        job(4'b0001, 1'b0, '0, 0, j_idx, j_lat, j_data, j_err, j_vld, j_stable, j_xg, j_va);
        n_tests++; if (j_idx !== 0 || j_err !== 1'b0) begin n_fail++; $display("FAIL done_release: got idx=%0d err=%b want 0/0", j_idx, j_err); end
    endtask

    task automatic test_reset_midjob();
        int cyc = 0;
        bit seen = 1'b0;
        longint e;
        rand_vec(3);
        req = 4'b1000;
        while (cyc < BUDGET && !seen) begin @(negedge clk); cyc++; if (gnt != '0) seen = 1'b1; end
        req = '0;
        n_tests++; if (!seen) begin n_fail++; $display("FAIL midrst_gnt: got none want grant"); end
        repeat (4) @(negedge clk);
        n_tests++; if (acc_start !== 1'b1) begin n_fail++; $display("FAIL midrst_running: got start=%b want 1", acc_start); end
        rst = 1'b1;
        #1;
        n_tests++; if (acc_start !== 1'b0 || busy !== 1'b0 || rsp_valid !== '0) begin n_fail++; $display("FAIL midrst_async: got start=%b busy=%b vld=%b want 0", acc_start, busy, rsp_valid); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rand_vec(3);
        e = dot(ra[3], rb[3]);
        job(4'b1000, 1'b0, '0, 0, j_idx, j_lat, j_data, j_err, j_vld, j_stable, j_xg, j_va);
        n_tests++; if (j_idx !== 3 || j_data !== e || j_lat !== 11) begin n_fail++; $display("FAIL midrst_recover: got idx=%0d data=%h lat=%0d want 3/%h/11", j_idx, j_data, j_lat, e); end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_single();
        test_signed();
        test_random();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_done_block();
        test_reset_midjob();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
